// File: rtl/lsu_wb_buffered_if.sv
// Wishbone data-bus bundle between the buffered LSU (master) and the memory system (slave).
interface wishbone #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic              we;
  logic [XLEN/8-1:0] sel;
  logic              stb;
  logic              cyc;
  logic              ack;

  modport MASTER (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
  modport SLAVE  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/lsu_wb_buffered.sv
// Load/store unit with a store buffer: stores retire into the buffer, the bus FSM drains it
// in order, and loads wait for an empty buffer before issuing a single read.
module lsu_wb_buffered #(
  parameter int XLEN       = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wishbone.MASTER         data_bus,
  input  logic [31:2]     instr,
  input  logic [XLEN-1:0] ieu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall,
  output logic            stalled,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  localparam int SELW = XLEN / 8;
  localparam int OFFW = $clog2(SELW);
  localparam int AW   = XLEN - OFFW;
  localparam int PTRW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNTW = $clog2(WBUF_DEPTH + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_n;

  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, legal;
  logic [OFFW-1:0] offset;
  logic [2:0]      size_mask;
  logic            off_bad, load_req, store_full, push, pop;
  logic [SELW-1:0] store_sel;
  logic [XLEN-1:0] store_dat;
  logic            unused_instr;

  logic [AW-1:0]   buf_addr [WBUF_DEPTH];
  logic [XLEN-1:0] buf_dat  [WBUF_DEPTH];
  logic [SELW-1:0] buf_sel  [WBUF_DEPTH];
  logic [PTRW-1:0] head, tail;
  logic [CNTW-1:0] count;

  logic [AW-1:0]   ld_addr;
  logic [OFFW-1:0] ld_off;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] shifted, load_ext;

  function automatic logic [SELW-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[SELW-1:0] << off;
  endfunction

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign opcode       = instr[6:2];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};
  assign is_load      = (opcode == 5'b00000);
  assign is_store     = (opcode == 5'b01000);
  assign offset       = ieu_result[OFFW-1:0];

  always_comb begin
    legal = 1'b1;
    if (funct3[1:0] == 2'b11 && XLEN == 32) legal = 1'b0;
    if (is_store && funct3[2])              legal = 1'b0;
    if (is_load && funct3 == 3'b111)        legal = 1'b0;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_mask = 3'd0;
      2'b01:   size_mask = 3'd1;
      2'b10:   size_mask = 3'd3;
      default: size_mask = 3'd7;
    endcase
  end

  assign off_bad    = |(offset & size_mask[OFFW-1:0]);
  assign misaligned = (is_load | is_store) & legal & off_bad;
  assign load_req   = is_load & legal & ~off_bad & ~stall;
  assign store_full = is_store & legal & ~off_bad & ~stall & (count == FULL);
  // Slot availability uses the registered count; a pop in the same cycle does not help.
  assign push       = is_store & legal & ~off_bad & ~stall & (count != FULL);
  assign pop        = (state == WRITE) & data_bus.ack;
  assign store_sel  = lane_mask(funct3[1:0], offset);

  always_comb begin
    store_dat = '0;
    for (int i = 0; i < SELW; i++)
      store_dat[8*i +: 8] = rs2_data[8*(i & int'(size_mask)) +: 8];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= ieu_result[XLEN-1:OFFW];
      buf_dat[tail]  <= store_dat;
      buf_sel[tail]  <= store_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ld_addr   <= '0;
      ld_off    <= '0;
      ld_funct3 <= '0;
      data      <= '0;
    end else begin
      state <= state_n;
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (state == IDLE && state_n == READ) begin
        ld_addr   <= ieu_result[XLEN-1:OFFW];
        ld_off    <= offset;
        ld_funct3 <= funct3;
      end
      if (state == READ && data_bus.ack) data <= load_ext;
    end
  end

  // A push in IDLE starts the write right away so the store reaches the bus next cycle.
  always_comb begin
    state_n = state;
    stalled = 1'b0;
    case (state)
      IDLE: begin
        stalled = load_req | store_full;
        if (load_req && count == '0)  state_n = READ;
        else if (count != '0 || push) state_n = WRITE;
      end
      WRITE: begin
        stalled = load_req | store_full;
        if (data_bus.ack) state_n = IDLE;
      end
      READ: begin
        stalled = 1'b1;
        if (data_bus.ack) state_n = DONE;
      end
      DONE: begin
        if (!stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    shifted  = data_bus.dat_r >> {ld_off, 3'b000};
    load_ext = shifted;
    case (ld_funct3[1:0])
      2'b00: begin
        if (ld_funct3[2]) load_ext = XLEN'(shifted[7:0]);
        else              load_ext = XLEN'($signed(shifted[7:0]));
      end
      2'b01: begin
        if (ld_funct3[2]) load_ext = XLEN'(shifted[15:0]);
        else              load_ext = XLEN'($signed(shifted[15:0]));
      end
      2'b10: begin
        if (ld_funct3[2]) load_ext = XLEN'(shifted[31:0]);
        else              load_ext = XLEN'($signed(shifted[31:0]));
      end
      default: load_ext = shifted;
    endcase
  end

  assign data_bus.cyc   = (state == WRITE) || (state == READ);
  assign data_bus.stb   = (state == WRITE) || (state == READ);
  assign data_bus.we    = (state == WRITE);
  assign data_bus.adr   = (state == WRITE) ? {buf_addr[head], OFFW'(0)} : {ld_addr, OFFW'(0)};
  assign data_bus.dat_w = (state == WRITE) ? buf_dat[head] : '0;
  assign data_bus.sel   = (state == WRITE) ? buf_sel[head] :
                          (state == READ)  ? lane_mask(ld_funct3[1:0], ld_off) : '0;
endmodule

// File: doc/lsu_wb_buffered.md
Name: lsu_wb_buffered

Overview:
- Load/store unit for the RV core that masters the data Wishbone bus.
- Successor to the single-transaction LSU: parametrised in XLEN (32/64), with a store buffer of WBUF_DEPTH entries so stores retire without waiting for the bus.
- Adds byte-lane steering (SEL), sub-word load alignment/extension and misalignment detection.
- Sits in the execute/memory stage, fed by the IEU result and rs2.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64; SELW = XLEN/8, OFFW = log2(SELW).
WBUF_DEPTH, 2, store buffer entries; power of two, >= 1.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
data_bus  wishbone.MASTER  -  uses ADR, DAT_W, DAT_R, WE, SEL[SELW-1:0], STB, CYC, ACK.
instr  input  [31:2]  current instruction; opcode instr[6:2] (LOAD 5'b00000, STORE 5'b01000), funct3 instr[14:12].
ieu_result  input  XLEN  effective address.
rs2_data  input  XLEN  store data.
stall  input  1  pipeline frozen; LSU accepts no new operation while high.
stalled  output  1  LSU holding the pipeline.
data  output  XLEN  load result (registered).
misaligned  output  1  current load/store is misaligned; no access performed.

Behaviour:
- Reset (async): FSM IDLE, buffer empty (count 0), data=0; CYC/STB/WE=0, SEL=0. Reset mid-transaction drops CYC immediately; buffered stores are discarded.
- Sizes: funct3[1:0] 00 B, 01 H, 10 W, 11 D (D only when XLEN=64). funct3[2]=1 means zero-extend (loads only). Illegal combinations: SD/LD on XLEN=32, funct3[2]=1 on store, LDU. These perform no access, keep stalled=0 and leave data unchanged.
- Misaligned: access size does not divide ieu_result[OFFW-1:0]. Then misaligned=1 combinationally, no push or bus access, stalled=0.
- Store accept:
  - Condition: STORE & !stall & !misaligned & count<WBUF_DEPTH (registered count; a same-cycle pop does not free a slot).
  - Pushes {addr[XLEN-1:OFFW], DAT_W, SEL}. stalled=0 that cycle.
  - Store with full buffer: stalled=1, no push.
- Store lane steering:
  - DAT_W = rs2 low bytes replicated across the bus width.
  - SEL = size mask (1, 3, F, FF) << addr offset.
- Bus FSM (outputs decoded from registered state):
  - IDLE:
    - If a load is pending (LOAD & !stall & legal & aligned) and the buffer is empty: latch address/funct3, go to READ.
    - Else if the buffer is non-empty: go to WRITE.
    - Loads never bypass buffered stores; there is no forwarding.
  - WRITE: CYC=STB=WE=1, ADR={head.addr, OFFW'b0}, DAT_W/SEL from head. On ACK: pop, go to IDLE.
  - READ:
    - CYC=STB=1, WE=0; ADR aligned as for WRITE; SEL from latched size/offset.
    - On ACK: shift DAT_R right by 8*offset, sign/zero-extend per funct3, register into data, go to DONE.
  - DONE: stalled=0, data valid. Stay in DONE while stall=1 (no reissue); go to IDLE when stall=0.
- stalled for a load: 1 from the first cycle the load is presented until DONE. Minimum load latency: present -> READ (+1) -> ACK -> DONE, i.e. 3 cycles with a zero-wait slave.
- CYC/STB are held until ACK; there are no back-to-back cycles without passing through IDLE.
- A store push and a WRITE pop may occur in the same cycle; count stays unchanged.

Test Plan:
1. SW 0xDEADBEEF @0x100, empty buffer -> stalled=0 in the same cycle. Next cycle: CYC=STB=WE=1, ADR=0x100, SEL=4'b1111, DAT_W=0xDEADBEEF. ACK -> count 0.
2. SB rs2=0x123456A5 @0x103 -> DAT_W=0xA5A5A5A5, SEL=4'b1000. SH @0x102 -> SEL=4'b1100.
3. WBUF_DEPTH=2, three consecutive stores, slave ACK after 3 wait cycles -> third store has stalled=1 until the cycle after the first ACK, then is accepted. Bus order is preserved.
4. SW @0x200 then LB @0x201, DAT_R=0x123480FF:
   - READ starts only after the write ACK.
   - data=0xFFFFFF80; LBU gives 0x00000080.
5. LH @0x102 with DAT_R=0x80010000 -> data=0xFFFF8001. LW @0x102 -> misaligned=1, CYC stays 0, stalled=0.
6. Hold stall=1 through DONE -> data held, exactly one READ. Pulse rst_n low during READ -> CYC=0 immediately, count=0, data=0.
